lfsr_seq_counter: RTL and testbench

Parametrised full-period pseudo-random counter, WIDTH 4..16, stepping through all 2^WIDTH states including all-zero, using an XOR LFSR with zero-state insertion. It adds seed load, synchronous clear, reversible stepping, a programmable compare-match pulse and a wrap pulse. It replaces fixed-width pseudo counters in timing and event-sequencing logic, where it is cheaper than a binary counter at high clock rates.

---
 rtl/lfsr_seq_counter.sv | 53 +++++
 tb/tb_lfsr_seq_counter.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_seq_counter.sv
// lfsr_seq_counter: full-period LFSR counter with zero-state insertion, seed load, clear,
// reversible stepping and registered compare-match / wrap pulses.
module lfsr_seq_counter #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] seed_i,
    input  logic             enable_i,
    input  logic             dir_i,
    input  logic [WIDTH-1:0] cmp_i,
    output logic [WIDTH-1:0] value_o,
    output logic             match_o,
    output logic             wrap_o
);
    if (WIDTH < 4 || WIDTH > 16) begin : g_bad_width
        $error("lfsr_seq_counter: WIDTH must be in 4..16");
    end
    localparam logic [15:0] TAPS =
        WIDTH == 4  ? 16'h000C : WIDTH == 5  ? 16'h0014 : WIDTH == 6  ? 16'h0030 :
        WIDTH == 7  ? 16'h0060 : WIDTH == 8  ? 16'h00B8 : WIDTH == 9  ? 16'h0110 :
        WIDTH == 10 ? 16'h0240 : WIDTH == 11 ? 16'h0500 : WIDTH == 12 ? 16'h0829 :
        WIDTH == 13 ? 16'h100D : WIDTH == 14 ? 16'h2015 : WIDTH == 15 ? 16'h6000 : 16'hD008;
    localparam logic [WIDTH-1:0] T  = TAPS[WIDTH-1:0];
    localparam logic [WIDTH-2:0] TL = T[WIDTH-2:0];
    logic [WIDTH-1:0] value_q, value_d, fwd, rev;
    logic             match_q, match_d, wrap_q, wrap_d;
    // Zero insertion: the all-zero-low-bits term splices state 0 into the maximal LFSR cycle.
    always_comb begin
        fwd     = {value_q[WIDTH-2:0], ^(value_q & T) ^ (value_q[WIDTH-2:0] == '0)};
        rev     = {value_q[0] ^ ^(value_q[WIDTH-1:1] & TL) ^ (value_q[WIDTH-1:1] == '0),
                   value_q[WIDTH-1:1]};
        value_d = clear_i ? '0 : load_i ? seed_i : !enable_i ? value_q : dir_i ? rev : fwd;
        wrap_d  = !clear_i && !load_i && enable_i && (dir_i ? value_q == '0 : fwd == '0);
        match_d = (clear_i || load_i || enable_i) && value_d == cmp_i;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q <= '0;
            match_q <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            value_q <= value_d;
            match_q <= match_d;
            wrap_q  <= wrap_d;
        end
    end
    assign value_o = value_q;
    assign match_o = match_q;
    assign wrap_o  = wrap_q;
endmodule

// File: tb/tb_lfsr_seq_counter.sv
// tb_lfsr_seq_counter: randomized self-checking bench against a tap-list reference model,
// with a width sweep of extra instances for period and reverse-from-zero checks.
module tb_lfsr_seq_counter;
    localparam int W  = 10;
    localparam int NS = 7;
    localparam int WS [NS] = '{4, 5, 6, 8, 12, 13, 16};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b0, clear = 1'b0, load = 1'b0, en = 1'b0, dir = 1'b0;
    logic [W-1:0] seed = '0, cmp = '0, value;
    logic match, wrap;
    int checks = 0, errs = 0;
    int ms = 0;
    logic em = 1'b0, ew = 1'b0;

    lfsr_seq_counter #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .clear_i(clear), .load_i(load), .seed_i(seed),
        .enable_i(en), .dir_i(dir), .cmp_i(cmp), .value_o(value), .match_o(match), .wrap_o(wrap)
    );

    logic sw_rst_n = 1'b0, sw_en = 1'b0, sw_dir = 1'b0;
    logic [15:0] sv [NS];
    logic sm [NS], swr [NS];
    bit seen [NS][65536];

    for (genvar g = 0; g < NS; g++) begin : g_sw
        logic [WS[g]-1:0] v;
        logic m, r;
        lfsr_seq_counter #(.WIDTH(WS[g])) u (
            .clk(clk), .rst_n(sw_rst_n), .clear_i(1'b0), .load_i(1'b0), .seed_i('0),
            .enable_i(sw_en), .dir_i(sw_dir), .cmp_i('0), .value_o(v), .match_o(m), .wrap_o(r)
        );
        assign sv[g]  = 16'(v);
        assign sm[g]  = m;
        assign swr[g] = r;
    end

    function automatic int taps(int w);
        case (w)
            4: return 'h000C;  5: return 'h0014;  6: return 'h0030;  7: return 'h0060;
            8: return 'h00B8;  9: return 'h0110; 10: return 'h0240; 11: return 'h0500;
            12: return 'h0829; 13: return 'h100D; 14: return 'h2015; 15: return 'h6000;
            16: return 'hD008;
            default: return 0;
        endcase
    endfunction

    function automatic int fwd(int s, int w);
        int fb;
        fb = ((s & ((1 << (w - 1)) - 1)) == 0) ? 1 : 0;
        for (int t = 0; t < w; t++) if (((taps(w) >> t) & 1) == 1) fb ^= (s >> t) & 1;
        return ((s << 1) | fb) & ((1 << w) - 1);
    endfunction

    // Predecessor found by trying both candidates for the top bit under the forward rule.
    function automatic int rev(int s, int w);
        int c;
        c = s >> 1;
        return fwd(c, w) == s ? c : c | (1 << (w - 1));
    endfunction

    task model;
        int n;
        ew = 1'b0;
        if (clear) n = 0;
        else if (load) n = int'(seed);
        else if (en && !dir) begin n = fwd(ms, W); ew = (n == 0); end
        else if (en) begin n = rev(ms, W); ew = (ms == 0); end
        else n = ms;
        em = (clear || load || en) && n == int'(cmp);
        ms = n;
    endtask

    task tick;
        model;
        @(posedge clk);
        #1;
    endtask

    task test_reset;
        #12;
        checks++;
        if (value !== '0 || match !== 1'b0 || wrap !== 1'b0) begin
            errs++;
            $display("FAIL reset_hold: value=%h match=%b wrap=%b, required 0/0/0", value, match, wrap);
        end
        @(negedge clk) rst_n = 1'b1;
        ms = 0;
        cmp = 10'h3FF;
        tick;
        checks++;
        if (value !== '0 || match !== 1'b0 || wrap !== 1'b0) begin
            errs++;
            $display("FAIL reset_release: value=%h match=%b wrap=%b, required 0/0/0", value, match, wrap);
        end
    endtask

    task test_forward_start;
        int exp [5];
        exp = '{1, 2, 4, 8, 16};
        en = 1'b1;
        dir = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick;
            checks++;
            if (value !== W'(exp[i]) || wrap !== 1'b0) begin
                errs++;
                $display("FAIL fwd_start[%0d]: value=%h wrap=%b, required %h/0", i, value, wrap, exp[i]);
            end
        end
        en = 1'b0;
    endtask

    task test_load_walk;
        int steps;
        load = 1'b1;
        seed = 10'h155;
        cmp = W'($urandom);
        tick;
        load = 1'b0;
        checks++;
        if (value !== 10'h155) begin
            errs++;
            $display("FAIL load_seed: value=%h, required 155", value);
        end
        for (int d = 0; d < 2; d++) begin
            dir = d[0];
            steps = 0;
            while (steps < 1000) begin
                en = ($urandom % 4) != 0;
                cmp = ($urandom % 3 == 0) ? W'(fwd(ms, W)) : W'($urandom);
                if (en) steps++;
                tick;
                checks++;
                if (value !== W'(ms) || match !== em || wrap !== ew) begin
                    errs++;
                    $display("FAIL walk dir=%0d: value=%h match=%b wrap=%b, required %h/%b/%b",
                             d, value, match, wrap, W'(ms), em, ew);
                end
            end
        end
        en = 1'b0;
        checks++;
        if (value !== 10'h155) begin
            errs++;
            $display("FAIL walk_return: value=%h, required 155", value);
        end
    endtask

    task test_match;
        int np;
        cmp = 10'h200;
        clear = 1'b1;
        tick;
        clear = 1'b0;
        en = 1'b1;
        dir = 1'b0;
        np = 0;
        for (int i = 0; i < 2048; i++) begin
            tick;
            if (match === 1'b1) np++;
            checks++;
            if (value !== W'(ms) || match !== em || wrap !== ew || (match === 1'b1 && value !== 10'h200)) begin
                errs++;
                $display("FAIL match_run: value=%h match=%b wrap=%b, required %h/%b/%b",
                         value, match, wrap, W'(ms), em, ew);
            end
        end
        checks++;
        if (np != 2) begin
            errs++;
            $display("FAIL match_count: pulses=%0d, required 2", np);
        end
        for (int i = 0; i < 1024 && value !== 10'h200; i++) tick;
        en = 1'b0;
        tick;
        checks++;
        if (match !== 1'b0 || value !== 10'h200) begin
            errs++;
            $display("FAIL match_hold: value=%h match=%b, required 200/0", value, match);
        end
    endtask

    task test_priority;
        cmp = '0;
        seed = 10'd5;
        clear = 1'b1;
        load = 1'b1;
        en = 1'b1;
        tick;
        checks++;
        if (value !== '0 || wrap !== 1'b0 || match !== 1'b1) begin
            errs++;
            $display("FAIL prio_clear: value=%h match=%b wrap=%b, required 0/1/0", value, match, wrap);
        end
        clear = 1'b0;
        tick;
        checks++;
        if (value !== 10'd5 || wrap !== 1'b0 || match !== 1'b0) begin
            errs++;
            $display("FAIL prio_load: value=%h match=%b wrap=%b, required 5/0/0", value, match, wrap);
        end
        load = 1'b0;
        en = 1'b0;
    endtask

    task test_back_to_back;
        seed = W'($urandom);
        load = 1'b1;
        tick;
        load = 1'b0;
        en = 1'b1;
        for (int i = 0; i < 200; i++) begin
            dir = i[0];
            cmp = W'(i[1] ? int'(seed) : fwd(ms, W));
            tick;
            checks++;
            if (value !== W'(ms) || match !== em || wrap !== ew || (i[0] && value !== seed)) begin
                errs++;
                $display("FAIL b2b[%0d]: value=%h match=%b wrap=%b, required %h/%b/%b",
                         i, value, match, wrap, W'(ms), em, ew);
            end
        end
        en = 1'b0;
    endtask

    task test_random;
        int sel;
        for (int i = 0; i < 1500; i++) begin
            clear = ($urandom % 16) == 0;
            load = ($urandom % 8) == 0;
            en = ($urandom % 2) == 0;
            dir = ($urandom % 2) == 0;
            seed = ($urandom % 4 == 0) ? '0 : W'($urandom);
            sel = $urandom % 5;
            cmp = sel == 0 ? W'(fwd(ms, W)) : sel == 1 ? W'(rev(ms, W)) : sel == 2 ? W'(ms) :
                  sel == 3 ? '0 : W'($urandom);
            tick;
            checks++;
            if (value !== W'(ms) || match !== em || wrap !== ew) begin
                errs++;
                $display("FAIL random[%0d]: value=%h match=%b wrap=%b, required %h/%b/%b",
                         i, value, match, wrap, W'(ms), em, ew);
            end
        end
        {clear, load, en, dir} = '0;
    endtask

    task test_async_reset;
        seed = 10'h0AB;
        load = 1'b1;
        tick;
        load = 1'b0;
        en = 1'b1;
        dir = 1'b0;
        tick;
        cmp = W'(fwd(ms, W));
        tick;
        rst_n = 1'b0;
        #2;
        checks++;
        if (value !== '0 || match !== 1'b0 || wrap !== 1'b0) begin
            errs++;
            $display("FAIL async_reset: value=%h match=%b wrap=%b, required 0/0/0", value, match, wrap);
        end
        @(negedge clk) rst_n = 1'b1;
        ms = 0;
        cmp = 10'd1;
        tick;
        checks++;
        if (value !== 10'd1 || match !== 1'b1 || wrap !== 1'b0) begin
            errs++;
            $display("FAIL after_reset_step: value=%h match=%b wrap=%b, required 1/1/0", value, match, wrap);
        end
        en = 1'b0;
    endtask

    task test_width_sweep;
        int mv [NS], bad [NS], first0 [NS], nw [NS], nm [NS], dup [NS];
        for (int k = 0; k < NS; k++) begin
            {mv[k], bad[k], first0[k], nw[k], nm[k], dup[k]} = '0;
            for (int s = 0; s < 65536; s++) seen[k][s] = 1'b0;
            seen[k][0] = 1'b1;
        end
        sw_en = 1'b1;
        sw_dir = 1'b0;
        @(negedge clk) sw_rst_n = 1'b1;
        for (int i = 1; i <= 65536; i++) begin
            @(posedge clk);
            #1;
            for (int k = 0; k < NS; k++) begin
                mv[k] = fwd(mv[k], WS[k]);
                if (sv[k] !== 16'(mv[k])) bad[k]++;
                if (swr[k] === 1'b1) nw[k]++;
                if (sm[k] === 1'b1) nm[k]++;
                if (i < (1 << WS[k])) begin
                    if (seen[k][sv[k]]) dup[k]++;
                    seen[k][sv[k]] = 1'b1;
                end
                if (first0[k] == 0 && sv[k] === 16'd0) first0[k] = i;
            end
        end
        for (int k = 0; k < NS; k++) begin
            checks++;
            if (bad[k] != 0 || dup[k] != 0 || first0[k] != (1 << WS[k]) ||
                nw[k] != (65536 >> WS[k]) || nm[k] != nw[k]) begin
                errs++;
                $display("FAIL sweep_w%0d: mism=%0d dup=%0d period=%0d wraps=%0d matches=%0d, required 0/0/%0d/%0d/%0d",
                         WS[k], bad[k], dup[k], first0[k], nw[k], nm[k], 1 << WS[k], 65536 >> WS[k], 65536 >> WS[k]);
            end
        end
        sw_rst_n = 1'b0;
        sw_dir = 1'b1;
        @(negedge clk) sw_rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < NS; k++) begin
            checks++;
            if (sv[k] !== 16'(rev(0, WS[k])) || swr[k] !== 1'b1) begin
                errs++;
                $display("FAIL sweep_rev_w%0d: value=%h wrap=%b, required %h/1", WS[k], sv[k], swr[k], rev(0, WS[k]));
            end
        end
        sw_en = 1'b0;
    endtask

    initial begin
        test_reset;
        test_forward_start;
        test_load_walk;
        test_match;
        test_priority;
        test_back_to_back;
        test_random;
        test_async_reset;
        test_width_sweep;
        $display("Simulation finished: %0d checks, %0d errors", checks, errs);
        $finish;
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
